bin2bcd_seq: RTL and testbench

- Iterative binary-to-BCD converter using shift-and-add-3 (double dabble), processing one input bit per clock.
- Sits directly upstream of bcd2bin in round-trip and display paths: it produces packed BCD digits, and the low two digits feed bcd2bin unchanged.
- Valid/ready handshake on both sides; one conversion in flight at a time.

---
 rtl/bin2bcd_seq_pkg.sv | 15 +
 rtl/bin2bcd_seq_if.sv | 26 ++
 rtl/bin2bcd_seq_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 89 ++++++++
 tb/tb_bin2bcd_seq.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared BCD constants and FSM encoding for the binary/BCD conversion blocks.
`timescale 1ns/1ps
package bcd_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/response bundle of the iterative binary-to-BCD converter.
`timescale 1ns/1ps
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; the source keeps valid and data steady until that edge.
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd
    );

endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// One double-dabble correction: a 4-bit digit of 5 or more gets 3 added, no carry out.
`timescale 1ns/1ps
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter: one shift-and-add-3 step per clock, one job in flight.
`timescale 1ns/1ps
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus,
    output state_t        state_o
);

    localparam int BW    = DIGITS * BCD_DIGIT_W;
    localparam int SW    = BW + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [SW-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BW-1:0]    bcd_q, bcd_d;

    logic [BW-1:0]    adj_digits;
    logic [SW-1:0]    shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .digit_o (adj_digits[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    // Adjust first, then shift; the adjusted top bit can never be set with legal parameters.
    assign shifted = {adj_digits[BW-2:0], scratch_q[WIDTH-1:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d   = ST_SHIFT;
                    scratch_d = {{BW{1'b0}}, bus.bin};
                    count_d   = CNT_W'(WIDTH);
                end
            end
            ST_SHIFT: begin
                scratch_d = shifted;
                count_d   = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    bcd_d   = shifted[SW-1:WIDTH];
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
    end

    assign bus.bcd = bcd_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: main 8-bit instance plus 4-bit and 16-bit parameter points.
`timescale 1ns/1ps
module tb_bin2bcd_seq;
    import bcd_pkg::*;

    localparam int W0 = 8;
    localparam int D0 = 3;
    localparam int W1 = 4;
    localparam int D1 = 2;
    localparam int W2 = 16;
    localparam int D2 = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        assert (10**D0 > 2**W0 - 1) else $fatal(1, "DIGITS too small for W0");
        assert (10**D1 > 2**W1 - 1) else $fatal(1, "DIGITS too small for W1");
        assert (10**D2 > 2**W2 - 1) else $fatal(1, "DIGITS too small for W2");
    end

    // ---------------- DUTs ----------------
    bin2bcd_seq_if #(.WIDTH(W0), .DIGITS(D0)) if0 ();
    bin2bcd_seq_if #(.WIDTH(W1), .DIGITS(D1)) if1 ();
    bin2bcd_seq_if #(.WIDTH(W2), .DIGITS(D2)) if2 ();
    state_t st0, st1, st2;

    bin2bcd_seq #(.WIDTH(W0), .DIGITS(D0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .state_o(st0));
    bin2bcd_seq #(.WIDTH(W1), .DIGITS(D1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .state_o(st1));
    bin2bcd_seq #(.WIDTH(W2), .DIGITS(D2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .state_o(st2));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] bin_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Decimal reference: repeated division, independent of the shift-and-add method.
    function automatic logic [31:0] ref_bcd(input int v, input int nd);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    logic [31:0] sb_exp, sb_bin;
    int          sb_rt;
    always @(negedge clk) begin
        if (rst_n && if0.out_valid && if0.out_ready) begin
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                sb_exp = exp_q.pop_front();
                sb_bin = bin_q.pop_front();
                check("bcd", 32'(if0.bcd), sb_exp);
                if (sb_bin < 100) begin
                    sb_rt = int'(if0.bcd[7:4]) * 10 + int'(if0.bcd[3:0]);
                    check("roundtrip", 32'(sb_rt), sb_bin);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int acc_cyc;

    task automatic send(input logic [W0-1:0] v, input bit track);
        int n;
        n = 0;
        while (!if0.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("send_timeout", 32'(if0.in_ready), 32'd1);
        if0.in_valid = 1'b1;
        if0.bin      = v;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        if0.in_valid = 1'b0;
        if0.bin      = W0'($urandom);
        if (track) begin
            exp_q.push_back(ref_bcd(int'(v), D0));
            bin_q.push_back(32'(v));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (st0 != ST_IDLE && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(st0), 32'(ST_IDLE));
    endtask

    task automatic run_w4(input logic [W1-1:0] v);
        int lat;
        lat = 0;
        if1.in_valid = 1'b1;
        if1.bin      = v;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        while (!if1.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w4_latency", 32'(lat), 32'(W1));
        check("w4_bcd", 32'(if1.bcd), ref_bcd(int'(v), D1));
        @(posedge clk); #1;
    endtask

    task automatic run_w16(input logic [W2-1:0] v);
        int lat;
        lat = 0;
        if2.in_valid = 1'b1;
        if2.bin      = v;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        while (!if2.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w16_latency", 32'(lat), 32'(W2));
        check("w16_bcd", 32'(if2.bcd), ref_bcd(int'(v), D2));
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, pulses, prev;
        rst_n = 1'b0;
        if0.in_valid = 1'b1; if0.bin = 8'd5; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.bin = '0;   if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.bin = '0;   if2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Handshake offered while reset is held must lose to reset.
        check("rst_state", 32'(st0), 32'(ST_IDLE));
        check("rst_in_ready", 32'(if0.in_ready), 32'd1);
        check("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check("rst_bcd", 32'(if0.bcd), 32'd0);
        if0.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency and return to idle
        send(8'd63, 1'b1);
        lat = 0;
        while (!if0.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(W0));
        check("bcd_63", 32'(if0.bcd), 32'h063);
        @(posedge clk); #1;
        check("in_ready_after_out", 32'(if0.in_ready), 32'd1);

        // Directed corner values
        send(8'd0, 1'b1);   wait_idle();
        send(8'd255, 1'b1); wait_idle();
        send(8'd100, 1'b1); wait_idle();
        send(8'd99, 1'b1);  wait_idle();

        // Backpressure with an ignored request while busy
        if0.out_ready = 1'b0;
        send(8'd200, 1'b1);
        lat = 0;
        while (!if0.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                if0.in_valid = 1'b1;
                if0.bin      = 8'd7;
            end
            @(posedge clk); #1;
            if0.in_valid = 1'b0;
            check("bp_out_valid", 32'(if0.out_valid), 32'd1);
            check("bp_bcd", 32'(if0.bcd), 32'h200);
            check("bp_in_ready", 32'(if0.in_ready), 32'd0);
        end
        if0.out_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        check("bp_ignored_req", 32'(st0), 32'(ST_IDLE));
        send(8'd7, 1'b1); wait_idle();

        // Reset in the middle of a conversion
        send(8'd150, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        bin_q.delete();
        check("midrst_out_valid", 32'(if0.out_valid), 32'd0);
        check("midrst_bcd", 32'(if0.bcd), 32'd0);
        check("midrst_in_ready", 32'(if0.in_ready), 32'd1);
        check("midrst_state", 32'(st0), 32'(ST_IDLE));
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (if0.out_valid) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        send(8'd42, 1'b1); wait_idle();

        // Full sweep, back-to-back with out_ready high
        prev = 0;
        for (int v = 0; v < 256; v++) begin
            send(W0'(v), 1'b1);
            if (v > 0) check("spacing", 32'(acc_cyc - prev), 32'(W0 + 2));
            prev = acc_cyc;
        end
        wait_idle();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Other parameter points
        run_w4(4'd15);
        run_w4(4'd9);
        run_w16(16'd65535);
        run_w16(16'd12345);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
